// File: rtl/uart_receiver_if.sv
// Consumer-side handshake of the UART receive stage: pop request, popped byte
// strobe and FIFO occupancy.
interface uart_receiver_if #(
    parameter int BUFFER_SIZE = 256
);
    localparam int CW = $clog2(BUFFER_SIZE) + 1;

    logic          read_valid;
    logic [7:0]    data_out;
    logic          data_out_valid;
    logic [CW-1:0] buffer_count;

    modport master (
        output read_valid,
        input  data_out,
        input  data_out_valid,
        input  buffer_count
    );

    modport slave (
        input  read_valid,
        output data_out,
        output data_out_valid,
        output buffer_count
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART deserializer feeding a byte FIFO; bytes are popped one per cycle
// to the loader while read_valid is high.
module uart_receiver #(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_FREQ  = 125_000_000,
    parameter int BUFFER_SIZE = 256
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           serial_in,
    uart_receiver_if.slave rd,
    output logic           frame_error,
    output logic           overflow
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(BUFFER_SIZE) + 1;
    localparam int PW               = $clog2(BUFFER_SIZE);
    localparam int TW               = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [TW-1:0] SAMPLE_LAST = TW'(SAMPLE_TIME - 1);
    localparam logic [TW-1:0] SYMBOL_LAST = TW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] FULL        = CW'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_t     state;
    logic [TW-1:0] ctr;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push_req;

    logic [7:0]    mem [BUFFER_SIZE];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [7:0]    data_q;
    logic          data_valid_q;

    // Two-flop synchronizer; flops reset to the idle-high line level.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            ctr         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            push_req    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            push_req    <= 1'b0;
            frame_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        ctr   <= '0;
                    end
                end
                START: begin
                    if (ctr == SAMPLE_LAST) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            ctr     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        ctr <= ctr + TW'(1);
                    end
                end
                DATA: begin
                    if (ctr == SYMBOL_LAST) begin
                        shift[bit_idx] <= rx_s;
                        ctr            <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        ctr <= ctr + TW'(1);
                    end
                end
                STOP: begin
                    // Re-arming at mid-stop-bit lets a back-to-back start edge be caught.
                    if (ctr == SYMBOL_LAST) begin
                        state <= IDLE;
                        ctr   <= '0;
                        if (rx_s) push_req    <= 1'b1;
                        else      frame_error <= 1'b1;
                    end else begin
                        ctr <= ctr + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: each variable gets a default first so no path can infer a latch.
        pop   = 1'b0;
        wr_en = 1'b0;
        drop  = 1'b0;
        if (rd.read_valid && (count != '0)) pop = 1'b1;
        if (push_req) begin
            if ((count != FULL) || pop) wr_en = 1'b1;
            else                        drop  = 1'b1;
        end
    end

    // NOTE: the storage array is not reset; count gates every read, so stale
    // contents are never observed.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wp] <= shift;
    end

    // A full FIFO with a simultaneous pop writes and reads the same slot; the
    // read returns the old (oldest) byte.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            data_valid_q <= pop;
            if (pop) begin
                data_q <= mem[rp];
                rp     <= rp + PW'(1);
            end
            if (wr_en) wp <= wp + PW'(1);
            if (drop) overflow <= 1'b1;
            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd.data_out       = data_q;
    assign rd.data_out_valid = data_valid_q;
    assign rd.buffer_count   = count;
endmodule

// File: tb/tb_uart_receiver.sv
// Randomized scoreboard bench for uart_receiver: a frame-level model predicts
// delivered bytes, frame errors and overflow; a monitor checks each strobe.
module tb_uart_receiver;
    localparam int BAUD = 100_000;
    localparam int CLKF = 1_000_000;
    localparam int BUF  = 4;
    localparam int SET  = CLKF / BAUD;

    logic clock     = 1'b0;
    logic reset     = 1'b0;
    logic serial_in = 1'b1;
    logic frame_error;
    logic overflow;

    uart_receiver_if #(.BUFFER_SIZE(BUF)) rd ();

    uart_receiver #(
        .BAUD_RATE  (BAUD),
        .CLOCK_FREQ (CLKF),
        .BUFFER_SIZE(BUF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .serial_in  (serial_in),
        .rd         (rd),
        .frame_error(frame_error),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int frame_edge = 0;
    int dv_count = 0;
    int fe_count = 0;
    int fe_exp = 0;
    int last_dv_edge = -1;
    int dv_run = 0;
    int last_run = 0;
    bit ov_exp = 1'b0;
    byte unsigned exp_q[$];
    byte unsigned mon_b;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe, independent of stimulus.
    always @(negedge clock) begin
        if (frame_error === 1'b1) fe_count++;
        if (rd.data_out_valid === 1'b1) begin
            dv_count++;
            dv_run++;
            last_dv_edge = edge_cnt + 1;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(rd.data_out_valid), 32'd0);
            end else begin
                mon_b = exp_q.pop_front();
                check("data_out", 32'(rd.data_out), 32'(mon_b));
            end
        end else begin
            if (dv_run != 0) last_run = dv_run;
            dv_run = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        ov_exp = 1'b0;
    endtask

    // Model: a good frame lands in the FIFO if there is room or a pop will
    // coincide with its push; otherwise it is dropped and overflow sets.
    task automatic send_frame(input byte unsigned b, input bit stop_ok, input bit pop_at_push);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        frame_edge = edge_cnt + 1;
        if (!stop_ok) fe_exp++;
        else if (rd.read_valid || pop_at_push || exp_q.size() < BUF) exp_q.push_back(b);
        else ov_exp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serial_in = f[i];
            repeat (SET) @(posedge clock);
            #1;
        end
        serial_in = 1'b1;
    endtask

    initial begin
        int dv0;
        byte unsigned rb;
        bit ok;

        // 1. Reset
        rd.read_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_data_out", 32'(rd.data_out), 32'd0);
        check("rst_valid", 32'(rd.data_out_valid), 32'd0);
        check("rst_count", 32'(rd.buffer_count), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(5);

        rd.read_valid = 1'b1;
        serial_in = 1'b0;
        idle(35);
        apply_reset();
        idle(150);
        check("midreset_no_valid", 32'(dv_count), 32'd0);
        check("midreset_count", 32'(rd.buffer_count), 32'd0);
        check("midreset_no_ferr", 32'(fe_count), 32'd0);

        // 2. Single frame latency
        dv0 = dv_count;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        check("single_strobes", 32'(dv_count - dv0), 32'd1);
        check("single_latency", 32'(last_dv_edge), 32'(frame_edge + 100));
        check("single_drained", 32'(exp_q.size()), 32'd0);

        // 3. Buffering
        rd.read_valid = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(20);
        check("buf_count", 32'(rd.buffer_count), 32'(exp_q.size()));
        check("buf_count3", 32'(rd.buffer_count), 32'd3);
        last_run = 0;
        rd.read_valid = 1'b1;
        idle(10);
        check("buf_burst_len", 32'(last_run), 32'd3);
        check("buf_count0", 32'(rd.buffer_count), 32'd0);
        check("buf_drained", 32'(exp_q.size()), 32'd0);

        // 4. Overflow
        rd.read_valid = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
        idle(20);
        check("ovf_count", 32'(rd.buffer_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'(ov_exp));
        rd.read_valid = 1'b1;
        idle(12);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_count0", 32'(rd.buffer_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        apply_reset();
        idle(2);
        check("ovf_cleared", 32'(overflow), 32'(ov_exp));

        // 5. Frame error and glitch
        dv0 = dv_count;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(30);
        check("ferr_pulses", 32'(fe_count), 32'(fe_exp));
        check("ferr_no_push", 32'(dv_count - dv0), 32'd0);
        check("ferr_count", 32'(rd.buffer_count), 32'd0);
        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        idle(50);
        check("glitch_no_ferr", 32'(fe_count), 32'(fe_exp));
        check("glitch_no_push", 32'(dv_count - dv0), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(20);
        check("glitch_recover", 32'(dv_count - dv0), 32'd1);

        // 6. Simultaneous push and pop at full
        apply_reset();
        rd.read_valid = 1'b0;
        idle(5);
        for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        idle(10);
        check("pp_full", 32'(rd.buffer_count), 32'd4);
        rb = 8'($urandom_range(0, 255));
        fork
            send_frame(rb, 1'b1, 1'b1);
            begin
                wait (edge_cnt == frame_edge + 97);
                #1;
                rd.read_valid = 1'b1;
                @(posedge clock);
                @(negedge clock);
                check("pp_count_held", 32'(rd.buffer_count), 32'd4);
            end
        join
        idle(15);
        check("pp_no_overflow", 32'(overflow), 32'd0);
        check("pp_drained", 32'(exp_q.size()), 32'd0);
        check("pp_count0", 32'(rd.buffer_count), 32'd0);

        // Randomized frames with random stop-bit errors and gaps
        for (int n = 0; n < 10; n++) begin
            ok = ($urandom_range(0, 3) != 0);
            send_frame(8'($urandom_range(0, 255)), ok, 1'b0);
            idle($urandom_range(2, 12));
        end
        idle(20);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_ferr", 32'(fe_count), 32'(fe_exp));
        check("rand_overflow", 32'(overflow), 32'(ov_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Serial-to-byte receive stage of the UART path.
- Deserializes 8N1 frames from `serial_in` and buffers the received bytes in a FIFO.
- Presents the bytes to the core loader on the `data_out` / `data_out_valid` strobe, which the loader consumes one byte per cycle.
- Sits directly upstream of the loader FSM in `core`, inside the UART controller's read path.

## Interface
Parameters:
- `BAUD_RATE`, 115_200: line bit rate.
- `CLOCK_FREQ`, 125_000_000: `clock` frequency in Hz.
- `BUFFER_SIZE`, 256: FIFO depth in bytes. Must be a power of two, ≥ 2.

Derived constants:
- `SYMBOL_EDGE_TIME` = `CLOCK_FREQ / BAUD_RATE`, in cycles per bit. Must be ≥ 4.
- `SAMPLE_TIME` = `SYMBOL_EDGE_TIME / 2`, using integer division.
- `CW` = `$clog2(BUFFER_SIZE) + 1`.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; state clears on an edge where `reset == 0`.
- `serial_in`  in  1  asynchronous RX line; idles high.
- `read_valid`  in  1  consumer request; pop one byte per cycle while high and the FIFO is non-empty.
- `data_out`  out  8  popped byte, registered.
- `data_out_valid`  out  1  one-cycle strobe, once per popped byte, registered.
- `buffer_count`  out  CW  number of bytes held in the FIFO.
- `frame_error`  out  1  one-cycle pulse when a frame's stop bit samples 0.
- `overflow`  out  1  sticky; set when a completed byte arrives while the FIFO is full.

## Operation
- **Input synchronizer:** `serial_in` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- **RX FSM** (`IDLE`, `START`, `DATA`, `STOP`) with cycle counter `ctr` and bit index `bit_idx` (0..7):
  - `IDLE`: when `rx_s == 0`, go to `START` with `ctr = 0`.
  - `START`: when `ctr == SAMPLE_TIME-1`, sample `rx_s`.
    - If 1, treat it as a glitch and return to `IDLE` with no output.
    - If 0, go to `DATA` with `ctr = 0` and `bit_idx = 0`.
  - `DATA`: when `ctr == SYMBOL_EDGE_TIME-1`, shift `rx_s` into `shift[bit_idx]` (LSB first) and set `ctr = 0`.
    - After `bit_idx == 7`, go to `STOP`.
  - `STOP`: when `ctr == SYMBOL_EDGE_TIME-1`, sample `rx_s`.
    - If 1, push `shift` to the FIFO.
    - If 0, pulse `frame_error` and discard the byte.
    - Either way, go to `IDLE`. Back-to-back frames are accepted because the FSM re-arms mid-stop-bit.
- **FIFO:** `BUFFER_SIZE` × 8 array with write pointer `wp`, read pointer `rp`, and `count`.
  - Pointers wrap modulo `BUFFER_SIZE`.
  - Push is requested in the cycle after the stop sample.
  - Pop occurs when `read_valid && count != 0`.
- **Push and pop in the same cycle:** both take effect and `count` is unchanged. When `count == BUFFER_SIZE`, pop-and-push is legal and nothing is dropped.
- **Full FIFO:** a push with `count == BUFFER_SIZE` and no simultaneous pop drops the byte and sets `overflow` = 1 until reset.
- **Empty FIFO:** `read_valid` with `count == 0` has no effect; `data_out_valid` = 0 and `data_out` holds its last value.
- **Pop output:** on a pop, `data_out <= mem[rp]` and `data_out_valid <= 1` on the next edge; otherwise `data_out_valid <= 0`.

## Timing
- **Reset values** (edge with `reset == 0`):
  - State: FSM `IDLE`; `ctr`, `bit_idx`, `wp`, `rp`, `count` all 0; synchronizer flops = 1.
  - Outputs: `data_out` = 0, `data_out_valid` = 0, `buffer_count` = 0, `frame_error` = 0, `overflow` = 0.
- **Reset mid-frame:** the partial byte is discarded and FIFO contents are lost.
- **Latency:** let E be the first edge at which `serial_in` is 0, with `read_valid` held at 1 and the FIFO initially empty.
  - The stop sample occurs at edge E + 2 + `SAMPLE_TIME` + 9·`SYMBOL_EDGE_TIME`.
  - The push is at the stop sample + 1; the pop at + 2; `data_out_valid` is high at + 3, for exactly one cycle.
- **Throughput:** one pop per cycle while `read_valid` = 1 and `count` > 0.
- **`buffer_count`:** reflects the registered `count`, updated on the same edge as the push or pop.
- **`frame_error`:** high during the cycle after the stop-bit sample edge.

## Test plan
Bench parameters: `BAUD_RATE` = 100_000, `CLOCK_FREQ` = 1_000_000 (`SYMBOL_EDGE_TIME` = 10, `SAMPLE_TIME` = 5), `BUFFER_SIZE` = 4.
1. **Reset:** hold `reset` = 0 for 3 cycles with `serial_in` = 1 → all outputs 0 and `buffer_count` = 0. A frame started, then reset mid-frame → no `data_out_valid` afterwards.
2. **Single frame:** send 0xA5 with `read_valid` = 1 → `data_out` = 0xA5 and `data_out_valid` high for exactly 1 cycle, at edge E + 100.
3. **Buffering:** `read_valid` = 0, send 0x01, 0x02, 0x03 back-to-back → `buffer_count` = 3. Then raise `read_valid` → three consecutive `data_out_valid` cycles with 0x01, 0x02, 0x03, and `buffer_count` = 0.
4. **Overflow:** `read_valid` = 0, send 5 bytes 0x10–0x14 → `buffer_count` = 4 and `overflow` = 1. Draining yields 0x10–0x13 only.
5. **Frame error and glitch:** send 0x3C with stop bit = 0 → a `frame_error` pulse and no push. A 3-cycle low glitch on an idle line → FSM back in `IDLE`, no push, no error.
6. **Simultaneous push and pop:** with `count` = 4 and `read_valid` = 1 in the push cycle, send a byte → `count` stays 4, `overflow` stays 0, and the bytes drain in order.
